// File: rtl/dlsc_axi_pkg.sv
// ============================================================================
// Module  : dlsc_axi_pkg
// Brief   : Shared AXI response codes and error-slave FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dlsc_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t c_RD_IDLE = 1'b0;
    localparam rd_state_t c_RD_DATA = 1'b1;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t c_WR_IDLE = 2'd0;
    localparam wr_state_t c_WR_DATA = 2'd1;
    localparam wr_state_t c_WR_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dlsc_axi_err_slave_rd.sv
// ============================================================================
// Module  : dlsc_axi_err_slave_rd
// Brief   : Read engine of the error slave: accepts AR, returns len+1 error
//           beats with zero data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dlsc_axi_err_slave_rd
    import dlsc_axi_pkg::*;
#(
    parameter int              DATA      = 32,
    parameter int              LEN       = 4,
    parameter int              RESP      = 2,
    parameter logic [RESP-1:0] RESP_CODE = AXI_RESP_DECERR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ar_ready,
    input  logic            ar_valid,
    input  logic [LEN-1:0]  ar_len,
    input  logic            r_ready,
    output logic            r_valid,
    output logic            r_last,
    output logic [DATA-1:0] r_data,
    output logic [RESP-1:0] r_resp
);

    rd_state_t      r_state;
    logic [LEN-1:0] r_cnt;
    logic           r_ar_ready;
    logic           r_r_valid;
    logic           r_r_last;
    logic           w_ar_hs;

    assign w_ar_hs = ar_valid && r_ar_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_RD_IDLE;
            r_cnt      <= '0;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
        end else begin
            case (r_state)
                c_RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_state    <= c_RD_DATA;
                        r_cnt      <= ar_len;
                        r_ar_ready <= 1'b0;
                        r_r_valid  <= 1'b1;
                        r_r_last   <= (ar_len == '0);
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                c_RD_DATA: begin
                    if (r_ready) begin
                        if (r_cnt == '0) begin
                            // Re-arm AR in the same edge that retires the last beat.
                            r_state    <= c_RD_IDLE;
                            r_ar_ready <= 1'b1;
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt - 1'b1;
                            r_r_last <= (r_cnt == LEN'(1));
                        end
                    end
                end
            endcase
        end
    end

    assign ar_ready = r_ar_ready;
    assign r_valid  = r_r_valid;
    assign r_last   = r_r_last;
    assign r_data   = '0;
    assign r_resp   = r_r_valid ? RESP_CODE : '0;

endmodule

`default_nettype wire

// File: rtl/dlsc_axi_err_slave.sv
// ============================================================================
// Module  : dlsc_axi_err_slave
// Brief   : AXI terminator answering every burst with a fixed error response.
//           Optional statistics enabled by DLSC_AXI_ERR_SLAVE_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dlsc_axi_err_slave
    import dlsc_axi_pkg::*;
#(
    parameter int              DATA      = 32,
    parameter int              ADDR      = 32,
    parameter int              LEN       = 4,
    parameter int              RESP      = 2,
    parameter logic [RESP-1:0] RESP_CODE = AXI_RESP_DECERR,
    parameter int              CNT       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ar_ready,
    input  logic              ar_valid,
    input  logic [ADDR-1:0]   ar_addr,
    input  logic [LEN-1:0]    ar_len,
    input  logic              r_ready,
    output logic              r_valid,
    output logic              r_last,
    output logic [DATA-1:0]   r_data,
    output logic [RESP-1:0]   r_resp,
    output logic              aw_ready,
    input  logic              aw_valid,
    input  logic [ADDR-1:0]   aw_addr,
    input  logic [LEN-1:0]    aw_len,
    output logic              w_ready,
    input  logic              w_valid,
    input  logic              w_last,
    input  logic [DATA/8-1:0] w_strb,
    input  logic [DATA-1:0]   w_data,
    input  logic              b_ready,
    output logic              b_valid,
    output logic [RESP-1:0]   b_resp,
    output logic [CNT-1:0]    err_rd_cnt,
    output logic [CNT-1:0]    err_wr_cnt,
    output logic [ADDR-1:0]   err_addr
);

    logic w_ar_hs;
    logic w_aw_hs;
    logic w_unused;

    dlsc_axi_err_slave_rd #(
        .DATA      (DATA),
        .LEN       (LEN),
        .RESP      (RESP),
        .RESP_CODE (RESP_CODE)
    ) u_rd (
        .clk      (clk),
        .rst_n    (rst_n),
        .ar_ready (ar_ready),
        .ar_valid (ar_valid),
        .ar_len   (ar_len),
        .r_ready  (r_ready),
        .r_valid  (r_valid),
        .r_last   (r_last),
        .r_data   (r_data),
        .r_resp   (r_resp)
    );

    assign w_ar_hs = ar_valid && ar_ready;

    // Write engine: command first, then data until w_last, then one B beat.
    wr_state_t r_wr_state;
    logic      r_aw_ready;
    logic      r_w_ready;
    logic      r_b_valid;

    assign w_aw_hs = aw_valid && r_aw_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= c_WR_IDLE;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
        end else begin
            case (r_wr_state)
                c_WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr_state <= c_WR_DATA;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                    end else begin
                        r_aw_ready <= 1'b1;
                    end
                end
                c_WR_DATA: begin
                    if (w_valid && w_last) begin
                        r_wr_state <= c_WR_RESP;
                        r_w_ready  <= 1'b0;
                        r_b_valid  <= 1'b1;
                    end
                end
                c_WR_RESP: begin
                    if (b_ready) begin
                        r_wr_state <= c_WR_IDLE;
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                    end
                end
                default: begin
                    r_wr_state <= c_WR_IDLE;
                    r_aw_ready <= 1'b0;
                    r_w_ready  <= 1'b0;
                    r_b_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign aw_ready = r_aw_ready;
    assign w_ready  = r_w_ready;
    assign b_valid  = r_b_valid;
    assign b_resp   = r_b_valid ? RESP_CODE : '0;

`ifdef DLSC_AXI_ERR_SLAVE_STATS_EN
    logic [CNT-1:0]  r_err_rd_cnt;
    logic [CNT-1:0]  r_err_wr_cnt;
    logic [ADDR-1:0] r_err_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_rd_cnt <= '0;
            r_err_wr_cnt <= '0;
            r_err_addr   <= '0;
        end else begin
            if (w_ar_hs && (r_err_rd_cnt != '1)) begin
                r_err_rd_cnt <= r_err_rd_cnt + 1'b1;
            end
            if (w_aw_hs && (r_err_wr_cnt != '1)) begin
                r_err_wr_cnt <= r_err_wr_cnt + 1'b1;
            end
            // Read address takes priority when both commands land together.
            if (w_ar_hs) begin
                r_err_addr <= ar_addr;
            end else if (w_aw_hs) begin
                r_err_addr <= aw_addr;
            end
        end
    end

    assign err_rd_cnt = r_err_rd_cnt;
    assign err_wr_cnt = r_err_wr_cnt;
    assign err_addr   = r_err_addr;
    assign w_unused   = ^{w_strb, w_data, aw_len};
`else
    assign err_rd_cnt = '0;
    assign err_wr_cnt = '0;
    assign err_addr   = '0;
    assign w_unused   = ^{w_strb, w_data, aw_len, ar_addr, aw_addr, w_ar_hs, w_aw_hs};
`endif

endmodule

`default_nettype wire
